// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB responder.
//   sccb_state_e   - responder FSM states
//   BITS_PER_PHASE - 8 data bits + 1 ack/don't-care slot
//   ID_RW_BIT      - read/write flag position inside the ID byte
//   id_match()     - ID compare ignoring the read/write flag
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID,
    SUB_HI,
    SUB_LO,
    WDATA,
    RDATA,
    IGNORE
  } sccb_state_e;

  localparam int          BITS_PER_PHASE    = 9;
  localparam int          ID_RW_BIT         = 0;
  localparam logic [7:0]  DEFAULT_DEVICE_ID = 8'h78;

  function automatic logic id_match(input logic [7:0] b, input logic [7:0] id);
    logic [7:0] mask;
    mask = ~(8'h01 << ID_RW_BIT);
    return ((b ^ id) & mask) == 8'h00;
  endfunction

endpackage

// File: rtl/sccb_target_if.sv
// sccb_target_if: register-port bundle between the SCCB responder and the
// register file it fronts.
//   reg_wr      - one-cycle write strobe
//   reg_rd_req  - one-cycle read request
//   reg_addr    - access address
//   reg_wdata   - write data, valid with reg_wr
//   reg_rdata   - read data, valid exactly one cycle after reg_rd_req
// modport master: the responder side; modport slave: the register file side.
interface sccb_target_if;
  logic        reg_wr;
  logic        reg_rd_req;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;

  modport master (output reg_wr, reg_rd_req, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_wr, reg_rd_req, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/sccb_line_filter.sv
// sccb_line_filter: 2-flop synchroniser + stability filter for one bus line.
//   sysclk, n_rst - clock, synchronous active-low reset
//   line          - raw pin
//   filt          - filtered level (resets to 1)
//   rise / fall   - one-cycle pulses, asserted in the cycle filt takes its new value
// The synchronised line must differ from filt for FILTER_LEN consecutive
// cycles before filt follows it, so pin-to-filt latency is 2+FILTER_LEN.
module sccb_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic sysclk,
  input  logic n_rst,
  input  logic line,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] LIM = 4'(FILTER_LEN - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge sysclk) begin
    if (!n_rst) begin
      sync <= 2'b11;
      filt <= 1'b1;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != filt) begin
        if (cnt == LIM) begin
          filt <= sync[1];
          cnt  <= '0;
          rise <= sync[1];
          fall <= ~sync[1];
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder decoding 3-phase writes and 2-phase write +
// 2-phase read transactions onto a 16-bit address / 8-bit data register port.
//   sysclk, n_rst - clock, synchronous active-low reset
//   scl           - serial clock from the initiator
//   sda           - open-drain serial data (driven 0 or z only)
//   rp            - register port (sccb_target_if.master)
//   active        - high while the FSM is not IDLE
// Build option: SCCB_TARGET_ACK_DRIVE_EN makes the responder pull sda low in
// the ack slot after a matching ID, sub-address and write-data byte.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID  = DEFAULT_DEVICE_ID,
  parameter int         FILTER_LEN = 3
) (
  input  logic              sysclk,
  input  logic              n_rst,
  input  logic              scl,
  inout  wire               sda,
  sccb_target_if.master     rp,
  output logic              active
);

`ifdef SCCB_TARGET_ACK_DRIVE_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  localparam logic [3:0] SLOT = 4'(BITS_PER_PHASE - 1);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .sysclk (sysclk), .n_rst (n_rst), .line (scl),
    .filt (scl_f), .rise (scl_rise), .fall (scl_fall)
  );

  sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .sysclk (sysclk), .n_rst (n_rst), .line (sda),
    .filt (sda_f), .rise (sda_rise), .fall (sda_fall)
  );

  sccb_state_e state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  tx, tx_n;
  logic [15:0] ptr, ptr_n;
  logic [15:0] addr, addr_n;
  logic [7:0]  wdata, wdata_n;
  logic        wr, wr_n;
  logic        rd_req, rd_req_n;
  logic        load_pend;
  logic        sda_oe, oe_n;
  logic        rd_sent, rd_sent_n;   // a data byte was shifted out; next slot is the initiator's ACK/NA
  logic        ack_slot, ack_slot_n; // we own the current ack slot
  logic [7:0]  in_byte;

  always_ff @(posedge sysclk) begin
    if (!n_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      ptr       <= '0;
      addr      <= '0;
      wdata     <= '0;
      wr        <= 1'b0;
      rd_req    <= 1'b0;
      load_pend <= 1'b0;
      sda_oe    <= 1'b0;
      rd_sent   <= 1'b0;
      ack_slot  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      wr        <= wr_n;
      rd_req    <= rd_req_n;
      load_pend <= rd_req;
      sda_oe    <= oe_n;
      rd_sent   <= rd_sent_n;
      ack_slot  <= ack_slot_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_n       = tx;
    ptr_n      = ptr;
    addr_n     = addr;
    wdata_n    = wdata;
    wr_n       = 1'b0;
    rd_req_n   = 1'b0;
    oe_n       = sda_oe;
    rd_sent_n  = rd_sent;
    ack_slot_n = ack_slot;
    in_byte    = {shreg[6:0], sda_f};

    // register file answers one cycle after the request
    if (load_pend) tx_n = rp.reg_rdata;

    // an scl edge masks any start/stop seen in the same cycle
    if (scl_rise || scl_fall) begin
      if (state != IDLE && scl_rise) begin
        if (bit_cnt != SLOT) begin
          shreg_n   = in_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == SLOT - 4'd1) begin
            case (state)
              ID: begin
                if (!id_match(in_byte, DEVICE_ID)) begin
                  state_n = IGNORE;
                end else if (in_byte[ID_RW_BIT]) begin
                  state_n    = RDATA;
                  rd_req_n   = 1'b1;
                  addr_n     = ptr;
                  ack_slot_n = ACK_EN;
                end else begin
                  state_n    = SUB_HI;
                  ack_slot_n = ACK_EN;
                end
              end
              SUB_HI: begin
                ptr_n[15:8] = in_byte;
                state_n     = SUB_LO;
                ack_slot_n  = ACK_EN;
              end
              SUB_LO: begin
                ptr_n[7:0] = in_byte;
                addr_n     = {ptr[15:8], in_byte};
                state_n    = WDATA;
                ack_slot_n = ACK_EN;
              end
              WDATA: begin
                wr_n       = 1'b1;
                wdata_n    = in_byte;
                addr_n     = ptr;
                ptr_n      = ptr + 16'd1;
                ack_slot_n = ACK_EN;
              end
              RDATA:   rd_sent_n = 1'b1;
              default: ;
            endcase
          end
        end else begin
          // ack slot sample
          bit_cnt_n  = '0;
          ack_slot_n = 1'b0;
          if (state == RDATA && rd_sent) begin
            rd_sent_n = 1'b0;
            if (sda_f) begin
              state_n = IGNORE;
            end else begin
              ptr_n    = ptr + 16'd1;
              addr_n   = ptr + 16'd1;
              rd_req_n = 1'b1;
            end
          end
        end
      end
      if (state != IDLE && scl_fall) begin
        if (state == RDATA && bit_cnt != SLOT)
          oe_n = ~tx[3'd7 - bit_cnt[2:0]];
        else if (ack_slot && bit_cnt == SLOT)
          oe_n = 1'b1;
        else
          oe_n = 1'b0;
      end
    end else if (scl_f && sda_fall) begin
      state_n    = ID;
      bit_cnt_n  = '0;
      oe_n       = 1'b0;
      rd_sent_n  = 1'b0;
      ack_slot_n = 1'b0;
    end else if (scl_f && sda_rise) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      oe_n       = 1'b0;
      rd_sent_n  = 1'b0;
      ack_slot_n = 1'b0;
    end
  end

  assign sda           = sda_oe ? 1'b0 : 1'bz;
  assign active        = (state != IDLE);
  assign rp.reg_wr     = wr;
  assign rp.reg_rd_req = rd_req;
  assign rp.reg_addr   = addr;
  assign rp.reg_wdata  = wdata;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bus-level bench acting as SCCB initiator and register file.
module tb_sccb_target;

  localparam int Q = 8;

  logic sysclk = 1'b0;
  logic n_rst  = 1'b0;
  logic scl    = 1'b1;
  logic m_oe   = 1'b0;
  logic active;
  wire  sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  sccb_target_if rp ();

  sccb_target #(.DEVICE_ID(8'h78), .FILTER_LEN(3)) dut (
    .sysclk (sysclk),
    .n_rst  (n_rst),
    .scl    (scl),
    .sda    (sda),
    .rp     (rp),
    .active (active)
  );

  always #5 sysclk = ~sysclk;

`ifdef SCCB_TARGET_ACK_DRIVE_EN
  localparam logic EXP_ACK = 1'b0;
`else
  localparam logic EXP_ACK = 1'b1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic dut_low = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];

  // register file model
  initial rp.reg_rdata = 8'h00;
  always @(posedge sysclk) if (rp.reg_rd_req) rp.reg_rdata <= rd_val;

  // scoreboard side: pop expectations as strobes appear
  always @(negedge sysclk) begin
    logic [23:0] ew;
    logic [15:0] er;
    if (!m_oe && sda === 1'b0) dut_low = 1'b1;
    if (rp.reg_wr) begin
      wr_cnt++;
      n_cmp++;
      if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_wr got addr=%h data=%h required no write", rp.reg_addr, rp.reg_wdata);
      end else begin
        ew = exp_wr_q.pop_front();
        if ({rp.reg_addr, rp.reg_wdata} !== ew) begin
          n_err++;
          $display("FAIL wr_access got %h/%h required %h/%h", rp.reg_addr, rp.reg_wdata, ew[23:8], ew[7:0]);
        end
      end
    end
    if (rp.reg_rd_req) begin
      rd_cnt++;
      n_cmp++;
      if (exp_rd_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rd got addr=%h required no read", rp.reg_addr);
      end else begin
        er = exp_rd_q.pop_front();
        if (rp.reg_addr !== er) begin
          n_err++;
          $display("FAIL rd_addr got %h required %h", rp.reg_addr, er);
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic bus_start();
    wclk(Q); m_oe = 1'b0;
    wclk(Q); scl = 1'b1;
    wclk(2*Q); m_oe = 1'b1;
    wclk(2*Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wclk(Q); m_oe = 1'b1;
    wclk(Q); scl = 1'b1;
    wclk(2*Q); m_oe = 1'b0;
    wclk(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      wclk(Q); m_oe = ~b[i];
      wclk(Q); scl = 1'b1;
      if (glitch && i == 7) begin
        wclk(Q); m_oe = ~m_oe;
        wclk(1); m_oe = ~m_oe;
        wclk(Q-1);
      end else begin
        wclk(2*Q);
      end
      scl = 1'b0;
    end
    wclk(Q); m_oe = 1'b0;
    wclk(Q); scl = 1'b1;
    wclk(Q); ack = sda;
    wclk(Q); scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wclk(Q); m_oe = 1'b0;
      wclk(Q); scl = 1'b1;
      wclk(Q); b[i] = sda;
      wclk(Q); scl = 1'b0;
    end
    wclk(Q); m_oe = ~nack;
    wclk(Q); scl = 1'b1;
    wclk(2*Q); scl = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; scl = 1'b1; m_oe = 1'b0;
    wclk(4);
    n_cmp++;
    if ({rp.reg_wr, rp.reg_rd_req, rp.reg_addr, rp.reg_wdata, active} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outputs got wr=%b rd=%b addr=%h wdata=%h active=%b required all 0",
               rp.reg_wr, rp.reg_rd_req, rp.reg_addr, rp.reg_wdata, active);
    end
    n_cmp++;
    if (sda !== 1'b1) begin
      n_err++;
      $display("FAIL reset_sda got %b required 1 (released)", sda);
    end
    n_rst = 1'b1;
    wclk(20);
  endtask

  task automatic test_write();
    logic [7:0] bytes [4] = '{8'h78, 8'h30, 8'h08, 8'h82};
    logic ack;
    int w0 = wr_cnt;
    exp_wr_q.push_back({16'h3008, 8'h82});
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], 1'b0, ack);
      n_cmp++;
      if (ack !== EXP_ACK) begin
        n_err++;
        $display("FAIL write_ack[%0d] got %b required %b", i, ack, EXP_ACK);
      end
    end
    bus_stop();
    wclk(10);
    n_cmp++;
    if (wr_cnt - w0 != 1) begin
      n_err++;
      $display("FAIL write_count got %0d required 1", wr_cnt - w0);
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL write_active_after_stop got %b required 0", active);
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] rb;
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    bus_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'h30, 1'b0, ack);
    send_byte(8'h0A, 1'b0, ack);
    bus_stop();
    n_cmp++;
    if (wr_cnt != w0) begin
      n_err++;
      $display("FAIL setup_no_wr got %0d writes required 0", wr_cnt - w0);
    end
    rd_val = 8'h56;
    exp_rd_q.push_back(16'h300A);
    bus_start();
    send_byte(8'h79, 1'b0, ack);
    n_cmp++;
    if (ack !== EXP_ACK) begin
      n_err++;
      $display("FAIL read_id_ack got %b required %b", ack, EXP_ACK);
    end
    read_byte(1'b1, rb);
    n_cmp++;
    if (rb !== 8'h56) begin
      n_err++;
      $display("FAIL read_data got %h required 56", rb);
    end
    bus_stop();
    wclk(10);
    n_cmp++;
    if (rd_cnt - r0 != 1) begin
      n_err++;
      $display("FAIL read_count got %0d required 1", rd_cnt - r0);
    end
    n_cmp++;
    if (active !== 1'b0 || sda !== 1'b1) begin
      n_err++;
      $display("FAIL read_idle got active=%b sda=%b required 0/1", active, sda);
    end
  endtask

  task automatic test_ignore();
    logic ack;
    logic [7:0] rb;
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    dut_low = 1'b0;
    bus_start();
    send_byte(8'h42, 1'b0, ack);
    send_byte(8'h30, 1'b0, ack);
    send_byte(8'h08, 1'b0, ack);
    send_byte(8'h82, 1'b0, ack);
    bus_stop();
    n_cmp++;
    if (wr_cnt != w0 || rd_cnt != r0) begin
      n_err++;
      $display("FAIL ignore_strobes got wr=%0d rd=%0d required 0/0", wr_cnt - w0, rd_cnt - r0);
    end
    n_cmp++;
    if (dut_low !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_sda_driven got %b required 0", dut_low);
    end
    // pointer must still be 300A
    rd_val = 8'hC3;
    exp_rd_q.push_back(16'h300A);
    bus_start();
    send_byte(8'h79, 1'b0, ack);
    read_byte(1'b1, rb);
    bus_stop();
    n_cmp++;
    if (rb !== 8'hC3) begin
      n_err++;
      $display("FAIL ignore_readback got %h required c3", rb);
    end
  endtask

  task automatic test_wrap();
    logic ack;
    int w0 = wr_cnt;
    exp_wr_q.push_back({16'hFFFF, 8'h11});
    exp_wr_q.push_back({16'h0000, 8'h22});
    bus_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'hFF, 1'b0, ack);
    send_byte(8'hFF, 1'b0, ack);
    send_byte(8'h11, 1'b0, ack);
    send_byte(8'h22, 1'b0, ack);
    bus_stop();
    wclk(5);
    n_cmp++;
    if (wr_cnt - w0 != 2) begin
      n_err++;
      $display("FAIL wrap_count got %0d required 2", wr_cnt - w0);
    end
  endtask

  task automatic test_glitch();
    logic ack;
    logic seen = 1'b0;
    int w0 = wr_cnt;
    // idle: one-cycle low pulse on sda with scl high
    @(negedge sysclk); m_oe = 1'b1;
    @(negedge sysclk); m_oe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (active) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_idle_start got active=%b required 0", seen);
    end
    // mid-transaction: one-cycle high pulse while scl high and sda low
    exp_wr_q.push_back({16'h3008, 8'h5A});
    bus_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'h30, 1'b1, ack);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_stop_decoded got active=%b required 1", active);
    end
    send_byte(8'h08, 1'b0, ack);
    send_byte(8'h5A, 1'b0, ack);
    bus_stop();
    wclk(5);
    n_cmp++;
    if (wr_cnt - w0 != 1) begin
      n_err++;
      $display("FAIL glitch_write_count got %0d required 1", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid();
    logic ack;
    int w0;
    rd_val = 8'h00;
    exp_rd_q.push_back(16'h3009);
    bus_start();
    send_byte(8'h79, 1'b0, ack);
    wclk(Q); m_oe = 1'b0;
    wclk(Q); scl = 1'b1;
    wclk(Q);
    n_cmp++;
    if (sda !== 1'b0) begin
      n_err++;
      $display("FAIL rdata_drive got sda=%b required 0", sda);
    end
    n_rst = 1'b0;
    @(posedge sysclk); #1;
    n_cmp++;
    if (sda !== 1'b1 || active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid got sda=%b active=%b required 1/0", sda, active);
    end
    wclk(3);
    n_rst = 1'b1;
    wclk(20);
    w0 = wr_cnt;
    exp_wr_q.push_back({16'h1234, 8'hAB});
    bus_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'h12, 1'b0, ack);
    send_byte(8'h34, 1'b0, ack);
    send_byte(8'hAB, 1'b0, ack);
    n_cmp++;
    if (ack !== EXP_ACK) begin
      n_err++;
      $display("FAIL post_reset_ack got %b required %b", ack, EXP_ACK);
    end
    bus_stop();
    wclk(5);
    n_cmp++;
    if (wr_cnt - w0 != 1) begin
      n_err++;
      $display("FAIL post_reset_write got %0d required 1", wr_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore();
    test_wrap();
    test_glitch();
    test_reset_mid();
    wclk(10);
    n_cmp++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_expectations got wr=%0d rd=%0d required 0/0", exp_wr_q.size(), exp_rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB responder (camera-side model / on-chip register target) on the same 2-wire bus our SCCB initiator drives.
- Oversamples SCL/SDA on sysclk and decodes 3-phase write and 2-phase write + 2-phase read transactions.
- Presents decoded accesses to a 16-bit-address, 8-bit-data register port.
- Used in simulation as the camera model and on-chip for loopback/self-test.

Parameters:
- DEVICE_ID, 8'h78: write ID; bit0 ignored on compare (read ID = DEVICE_ID|1).
- FILTER_LEN, 3: sysclk cycles a synchronised line must be stable before its filtered value changes; range 1..15.

Ports:
- sysclk  input  1  system clock
- n_rst  input  1  reset, synchronous, active-low
- scl  input  1  serial clock from initiator
- sda  inout  1  serial data; driven only as 1'b0 or 1'bz (open-drain)
- reg_wr  output  1  one-sysclk write strobe
- reg_rd_req  output  1  one-sysclk read request
- reg_addr  output  16  access address (sub-address pointer)
- reg_wdata  output  8  write data, valid with reg_wr
- reg_rdata  input  8  read data, must be valid exactly 1 sysclk after reg_rd_req
- active  output  1  high while state != IDLE

Behaviour:
- Clock and reset: one clock (sysclk); reset is synchronous and active-low (n_rst).
- Reset values: reg_wr=0, reg_rd_req=0, reg_addr=0, reg_wdata=0, active=0, sda released (z), state=IDLE, pointer=0, filtered lines=1.
- Reset asserted mid-transaction: sda released in the cycle after the reset edge; bus ignored until the next start.
- Line conditioning: 2-flop synchroniser per line (reset to 1). Glitch filter per FILTER_LEN, giving scl_f/sda_f. Latency from pin to filtered value: 2+FILTER_LEN cycles.
- Start/stop detection:
  - Start = sda_f falling while scl_f=1. Accepted in any state, so a repeated start is valid. Goes to ID with bit_cnt=0.
  - Stop = sda_f rising while scl_f=1. Goes to IDLE and releases sda.
- Bit timing: sample on scl_f rising edge, MSB first. Change driven sda only on scl_f falling edge. bit_cnt runs 0..8; bit 8 is the ack/don't-care slot.
- States: IDLE, ID, SUB_HI, SUB_LO, WDATA, RDATA, IGNORE.
  - ID:
    - ID[7:1] != DEVICE_ID[7:1] → IGNORE. Never drives sda; exits only on start/stop.
    - bit0=0 → SUB_HI.
    - bit0=1 → RDATA, with reg_rd_req pulsed on the byte-complete cycle and reg_addr=pointer.
  - SUB_HI: pointer[15:8]=byte, then SUB_LO.
  - SUB_LO: pointer[7:0]=byte, then WDATA. reg_addr follows the pointer.
  - WDATA: each completed byte pulses reg_wr for one cycle with reg_wdata=byte and reg_addr=pointer. Pointer then increments (16'hFFFF wraps to 16'h0000). Stays in WDATA for further bytes.
  - RDATA:
    - Shift-out register loads reg_rdata 1 cycle after reg_rd_req.
    - Bits 0..7: at each scl_f falling edge, drive low iff the next bit is 0, else release.
    - Slot 8: released; initiator's bit sampled on the scl_f rising edge.
    - Slot bit 1 (NA) → IGNORE.
    - Slot bit 0 → pointer increments, reg_rd_req pulses again, next byte.
- Three-phase write followed by stop without data: pointer latched, no reg_wr. This is the setup half of a read.
- Simultaneous scl_f and sda_f change in one cycle: the scl edge wins. No start/stop is decoded that cycle.

Optional Feature:
- Macro SCCB_TARGET_ACK_DRIVE_EN.
- Defined: in slot 8 after ID (match), SUB_HI, SUB_LO and WDATA bytes, drive sda low from the falling edge ending bit 7 to the next falling edge (I2C-style ACK).
- Undefined: sda released in all slot-8 periods (pure SCCB don't-care). The initiator sees the pull-up as 1.

Decomposition:
- Package sccb_pkg: state enum typedef, BITS_PER_PHASE=9, ID_RW_BIT=0, default ID 8'h78.
- Sub-module sccb_line_filter: synchroniser, glitch filter and rise/fall pulse outputs. Instantiated once for scl and once for sda.

Test Plan:
- Write 0x78, 0x30, 0x08, 0x82, stop → exactly one reg_wr, reg_addr=16'h3008, reg_wdata=8'h82; active low after stop.
- Write 0x78, 0x30, 0x0A, stop; start, 0x79; reg_rdata=8'h56 → reg_rd_req once with addr 16'h300A; sampled SDA byte = 0x56; NA=1; stop → IDLE, sda z.
- ID 0x42 full write → no reg_wr/reg_rd_req; sda never driven low; pointer unchanged.
- Write 0x78, 0xFF, 0xFF, 0x11, 0x22 → reg_wr at 16'hFFFF (0x11) then 16'h0000 (0x22).
- One-sysclk low glitch on sda while scl=1 (FILTER_LEN=3) → no start/stop decoded, state unchanged.
- n_rst low during RDATA while driving 0 → sda z next cycle; subsequent 0x78 write decodes correctly. With ACK_DRIVE_EN, slot-8 sda=0 after each write byte.
